bcd_counter: RTL and testbench

BCD_COUNTER -- requirements
Module: bcd_counter

---
 rtl/bcd_counter.sv | 106 ++++++++++
 tb/tb_bcd_counter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter.sv
// bcd_counter -- free-running cascaded decimal (BCD) counter.
//
// Counts up by one decimal unit on every rising clk edge while reset is
// high. Each 4-bit decade steps 0..9 and wraps; a decade advances only
// when every lower decade is rolling over from 9. A decade holding a
// non-BCD code (10-15, e.g. after an upset) is cleared on the next edge
// and passes a carry upward, so the counter heals itself.
//
// Parameters:
//   NUM_DIGITS  - number of cascaded decades (1..8)
//   RESET_VALUE - decimal value loaded while reset is low (< 10^NUM_DIGITS)
//
// Ports:
//   clk            - clock, rising-edge active
//   reset          - asynchronous reset, active low
//   count          - packed BCD value, digit k in count[4k+3:4k]
//   digit_carry    - bit k high while digits k..0 all equal 9
//   terminal_count - high while every digit equals 9
module bcd_counter #(
  parameter int NUM_DIGITS  = 1,
  parameter int RESET_VALUE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [NUM_DIGITS-1:0]   digit_carry,
  output logic                    terminal_count
);

  localparam int W = 4 * NUM_DIGITS;

  // Convert the decimal reset value into packed BCD at elaboration time.
  function automatic logic [W-1:0] to_bcd(input int unsigned value);
    logic [W-1:0] res;
    int unsigned  v;
    res = '0;
    v   = value;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      res[4*k +: 4] = 4'(v % 10);
      v             = v / 10;
    end
    return res;
  endfunction

  localparam logic [W-1:0] RESET_BCD = to_bcd(RESET_VALUE);

  logic [W-1:0]          count_q;
  logic [W-1:0]          count_d;
  logic [NUM_DIGITS-1:0] nine;

  // Per-decade "equals 9" decode.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nine
      assign nine[gi] = (count_q[4*gi +: 4] == 4'd9);
    end
  endgenerate

  // Next-state ripple. 'carry' is the increment request entering decade k:
  // always 1 for the units, then propagated by a 9->0 rollover or by an
  // illegal code being cleared.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    count_d = count_q;
    carry   = 1'b1;
    dig     = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dig = count_q[4*k +: 4];
      if (dig > 4'd9) begin
        count_d[4*k +: 4] = 4'd0;
        carry             = 1'b1;
      end else if (carry) begin
        if (nine[k]) begin
          count_d[4*k +: 4] = 4'd0;
        end else begin
          count_d[4*k +: 4] = dig + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // Status flags are a pure decode of the count register. An illegal
  // digit does not raise digit_carry; only a genuine run of 9s does.
  always_comb begin
    logic all_nine;
    all_nine    = 1'b1;
    digit_carry = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      all_nine       = all_nine & nine[k];
      digit_carry[k] = all_nine;
    end
    terminal_count = digit_carry[NUM_DIGITS-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RESET_BCD;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_bcd_counter.sv
// tb_bcd_counter -- directed self-checking bench for bcd_counter.
// dut1: single decade (default parameters). dut2: two decades.
module tb_bcd_counter;

  logic       clk;
  logic       rst1;
  logic       rst2;
  logic [3:0] count1;
  logic [0:0] dc1;
  logic       tc1;
  logic [7:0] count2;
  logic [1:0] dc2;
  logic       tc2;

  int checks;
  int errors;

  bcd_counter dut1 (
    .clk            (clk),
    .reset          (rst1),
    .count          (count1),
    .digit_carry    (dc1),
    .terminal_count (tc1)
  );

  bcd_counter #(.NUM_DIGITS(2), .RESET_VALUE(0)) dut2 (
    .clk            (clk),
    .reset          (rst2),
    .count          (count2),
    .digit_carry    (dc2),
    .terminal_count (tc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-up: reset low for well over 15 ns, count must sit at 0 across edges.
  task automatic test_reset();
    rst1 = 1'b1;
    rst2 = 1'b1;
    #1;
    rst1 = 1'b0;
    rst2 = 1'b0;
    #1;
    checks++;
    if (count1 !== 4'd0 || tc1 !== 1'b0 || dc1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: count=%h tc=%b dc=%b required count=0 tc=0 dc=0", count1, tc1, dc1);
    end
    checks++;
    if (count2 !== 8'h00 || tc2 !== 1'b0 || dc2 !== 2'b00) begin
      errors++;
      $display("FAIL reset_async2: count=%h tc=%b dc=%b required 00/0/00", count2, tc2, dc2);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (count1 !== 4'd0 || tc1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: count=%h tc=%b required count=0 tc=0", i, count1, tc1);
      end
    end
    $display("reset: count1=%h count2=%h held across edges", count1, count2);
  endtask

  // Free run: 15 edges after release give 1..9,0,1..5.
  task automatic test_free_run();
    logic [3:0] exp;
    rst1 = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      exp = 4'(i % 10);
      checks++;
      if (count1 !== exp || count1 > 4'd9) begin
        errors++;
        $display("FAIL free_run[%0d]: count=%h required %h", i, count1, exp);
      end
      checks++;
      if (tc1 !== (exp == 4'd9) || dc1[0] !== (exp == 4'd9)) begin
        errors++;
        $display("FAIL free_run_flags[%0d]: tc=%b dc=%b required %b", i, tc1, dc1, (exp == 4'd9));
      end
      $display("free_run edge %0d: count=%h tc=%b", i, count1, tc1);
    end
  endtask

  // Flags at 9 and clean wrap to 0 (starting from count 5).
  task automatic test_wrap_flags();
    repeat (3) @(negedge clk);
    checks++;
    if (count1 !== 4'd8 || tc1 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_at8: count=%h tc=%b required 8/0", count1, tc1);
    end
    @(negedge clk);
    checks++;
    if (count1 !== 4'd9 || tc1 !== 1'b1 || dc1 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_at9: count=%h tc=%b dc=%b required 9/1/1", count1, tc1, dc1);
    end
    @(negedge clk);
    checks++;
    if (count1 !== 4'd0 || tc1 !== 1'b0 || dc1 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_to0: count=%h tc=%b dc=%b required 0/0/0", count1, tc1, dc1);
    end
    $display("wrap_flags: count=%h tc=%b dc=%b after wrap", count1, tc1, dc1);
  endtask

  // Reset asserted between edges at count 6, held, then first increment.
  task automatic test_async_reset();
    repeat (6) @(negedge clk);
    checks++;
    if (count1 !== 4'd6) begin
      errors++;
      $display("FAIL async_pre: count=%h required 6", count1);
    end
    #1;
    rst1 = 1'b0;
    #1;
    checks++;
    if (count1 !== 4'd0) begin
      errors++;
      $display("FAIL async_immediate: count=%h required 0", count1);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (count1 !== 4'd0 || tc1 !== 1'b0) begin
      errors++;
      $display("FAIL async_hold: count=%h tc=%b required 0/0", count1, tc1);
    end
    rst1 = 1'b1;
    @(negedge clk);
    checks++;
    if (count1 !== 4'd1) begin
      errors++;
      $display("FAIL async_first_inc: count=%h required 1", count1);
    end
    $display("async_reset: count=%h after release and one edge", count1);
  endtask

  // Two decades: 100 edges from 00, checking value and both flags.
  task automatic test_multi_digit();
    logic [7:0] exp;
    int         n;
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    checks++;
    if (count2 !== 8'h00) begin
      errors++;
      $display("FAIL md_reset: count=%h required 00", count2);
    end
    @(negedge clk);
    rst2 = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      n   = i % 100;
      exp = {4'(n / 10), 4'(n % 10)};
      checks++;
      if (count2 !== exp || tc2 !== (n == 99) || dc2[0] !== (n % 10 == 9) || dc2[1] !== (n == 99)) begin
        errors++;
        $display("FAIL md_step[%0d]: count=%h tc=%b dc=%b required %h tc=%b", i, count2, tc2, dc2, exp, (n == 99));
      end
      if (n == 10 || n == 99 || n == 0) begin
        $display("multi_digit edge %0d: count=%h tc=%b dc=%b", i, count2, tc2, dc2);
      end
    end
  endtask

  // Inject non-BCD codes into the state registers and check recovery.
  task automatic inject2(input logic [7:0] bad, input logic [7:0] exp, input string name);
    @(negedge clk);
    force dut2.count_q = bad;
    #1;
    release dut2.count_q;
    @(negedge clk);
    checks++;
    if (count2 !== exp) begin
      errors++;
      $display("FAIL %s: count=%h required %h", name, count2, exp);
    end
    $display("illegal %s: injected %h -> %h", name, bad, count2);
  endtask

  task automatic test_illegal();
    inject2(8'h0C, 8'h10, "units_C");
    @(negedge clk);
    checks++;
    if (count2 !== 8'h11) begin
      errors++;
      $display("FAIL units_C_next: count=%h required 11", count2);
    end
    inject2(8'hA5, 8'h06, "tens_A");
    inject2(8'hC9, 8'h00, "tens_C_units_9");
    inject2(8'h3F, 8'h40, "units_F");
    @(negedge clk);
    force dut1.count_q = 4'hC;
    #1;
    release dut1.count_q;
    @(negedge clk);
    checks++;
    if (count1 !== 4'd0 || tc1 !== 1'b0) begin
      errors++;
      $display("FAIL single_C: count=%h tc=%b required 0/0", count1, tc1);
    end
    @(negedge clk);
    checks++;
    if (count1 !== 4'd1) begin
      errors++;
      $display("FAIL single_C_next: count=%h required 1", count1);
    end
    $display("illegal single digit: recovered to %h", count1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_free_run();
    test_wrap_flags();
    test_async_reset();
    test_multi_digit();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
